// File: rtl/puf_sched_pkg.sv
// Shared definitions for the PUF response scheduler: state encoding, default
// parameter values and the width helpers used by the scheduler and its buffer.
package puf_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETUP,
    S_EXEC,
    S_STORE,
    S_RESP
  } sched_state_t;

  localparam int unsigned DEF_MUX_LENGTH   = 16;
  localparam int unsigned DEF_NUM_CHAL     = 8;
  localparam int unsigned DEF_CNT_BIT_SIZE = 32;
  localparam int unsigned DEF_WDOG_LIMIT   = 1024;

  // Mux select width; a single-RO mux still needs a 1-bit select port.
  function automatic int unsigned sel_width(input int unsigned mux_length);
    return (mux_length <= 2) ? 1 : $clog2(mux_length);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/puf_chal_buf.sv
// Challenge register file: NUM_CHAL words written in order through a write
// pointer, with a fill count and an asynchronous read port indexed by the FSM.
module puf_chal_buf
  import puf_sched_pkg::*;
#(
  parameter int unsigned NUM_CHAL = DEF_NUM_CHAL,
  parameter int unsigned WORD_W   = 8,
  localparam int unsigned IDX_W   = ptr_width(NUM_CHAL),
  localparam int unsigned CNT_W   = $clog2(NUM_CHAL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              clear,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  logic [WORD_W-1:0] mem [NUM_CHAL];
  logic [IDX_W-1:0]  wr_ptr;

  assign full    = (count == CNT_W'(NUM_CHAL));
  assign rd_data = mem[rd_idx];

  // Reset wipes the stored words so an aborted batch leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(NUM_CHAL); i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push && !full) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + IDX_W'(1);
      count       <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/puf_resp_sched.sv
// PUF response scheduler: buffers challenges, runs one RO race per challenge and
// returns the packed response. Optional EXEC watchdog: PUF_RESP_SCHED_WDOG_EN.
module puf_resp_sched
  import puf_sched_pkg::*;
#(
  parameter int unsigned MUX_LENGTH   = DEF_MUX_LENGTH,
  parameter int unsigned NUM_CHAL     = DEF_NUM_CHAL,
  parameter int unsigned CNT_BIT_SIZE = DEF_CNT_BIT_SIZE,
  parameter int unsigned WDOG_LIMIT   = DEF_WDOG_LIMIT,
  localparam int unsigned SEL_W       = sel_width(MUX_LENGTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_chal_valid,
  output logic                    o_chal_ready,
  input  logic [2*SEL_W-1:0]      i_chal_data,
  input  logic                    i_start,
  input  logic [CNT_BIT_SIZE-1:0] i_max_count,
  output logic [SEL_W-1:0]        o_sel_mux_0,
  output logic [SEL_W-1:0]        o_sel_mux_1,
  output logic [CNT_BIT_SIZE-1:0] o_max_count,
  output logic                    o_sft_rst,
  output logic                    o_exec_enable,
  input  logic                    i_exec_done,
  input  logic                    i_winner,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [NUM_CHAL-1:0]     o_resp_data,
  output logic                    o_busy,
  output logic                    o_err,
  output logic                    o_timeout
);

  localparam int unsigned IDX_W = ptr_width(NUM_CHAL);
  localparam int unsigned CNT_W = $clog2(NUM_CHAL + 1);

  sched_state_t         state;
  logic [IDX_W-1:0]     idx;
  logic [NUM_CHAL-1:0]  resp;
  logic [2*SEL_W-1:0]   rd_data;
  logic [CNT_W-1:0]     buf_count;
  logic                 buf_full;
  logic                 chal_ready;
  logic                 push;
  logic                 start_ok;
  logic                 buf_clear;
  logic                 last_chal;
  logic                 wdog_expire;
  logic [SEL_W-1:0]     rd_sel0;
  logic [SEL_W-1:0]     rd_sel1;

  // Ready is gated by rst_n so it reads 0 while reset is held.
  assign chal_ready = rst_n && (state == S_IDLE) && !buf_full;
  assign push       = i_chal_valid && chal_ready;
  // A word arriving in the same cycle as start counts toward the batch.
  assign start_ok   = (state == S_IDLE) && i_start && ((buf_count != '0) || push);
  assign buf_clear  = (state == S_RESP) && i_resp_ready;
  assign last_chal  = ((CNT_W'(idx) + CNT_W'(1)) == buf_count);
  assign rd_sel0    = rd_data[SEL_W-1:0];
  assign rd_sel1    = rd_data[2*SEL_W-1:SEL_W];

  assign o_chal_ready = chal_ready;
  assign o_busy       = (state != S_IDLE);
  assign o_resp_data  = resp;

  puf_chal_buf #(
    .NUM_CHAL (NUM_CHAL),
    .WORD_W   (2*SEL_W)
  ) u_chal_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (i_chal_data),
    .clear     (buf_clear),
    .rd_idx    (idx),
    .rd_data   (rd_data),
    .count     (buf_count),
    .full      (buf_full)
  );

`ifdef PUF_RESP_SCHED_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              timeout;

  // Expiry fires on the WDOG_LIMIT-th EXEC cycle without a done from the datapath.
  assign wdog_expire = (state == S_EXEC) && !i_exec_done &&
                       (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));
  assign o_timeout   = timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state != S_EXEC) begin
        wdog_cnt <= '0;
      end else if (!i_exec_done && !wdog_expire) begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end
      if (start_ok) begin
        timeout <= 1'b0;
      end else if (wdog_expire) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  localparam int unsigned WDOG_LIMIT_UNUSED = WDOG_LIMIT;

  assign wdog_expire = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  // Main sequencer; every datapath control output is a register written here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      resp          <= '0;
      o_sel_mux_0   <= '0;
      o_sel_mux_1   <= '0;
      o_max_count   <= '0;
      o_sft_rst     <= 1'b0;
      o_exec_enable <= 1'b0;
      o_resp_valid  <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            o_max_count <= i_max_count;
            idx         <= '0;
            resp        <= '0;
            o_err       <= 1'b0;
            o_sft_rst   <= 1'b1;
            state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          o_sft_rst <= 1'b0;
          state     <= S_SETUP;
        end
        S_SETUP: begin
          o_sel_mux_0 <= rd_sel0;
          o_sel_mux_1 <= rd_sel1;
          // Racing an RO against itself is meaningless: record 0 and flag it.
          if (rd_sel0 == rd_sel1) begin
            resp[idx] <= 1'b0;
            o_err     <= 1'b1;
            state     <= S_STORE;
          end else begin
            o_exec_enable <= 1'b1;
            state         <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (i_exec_done) begin
            resp[idx]     <= i_winner;
            o_exec_enable <= 1'b0;
            state         <= S_STORE;
          end else if (wdog_expire) begin
            resp[idx]     <= 1'b0;
            o_exec_enable <= 1'b0;
            state         <= S_STORE;
          end
        end
        S_STORE: begin
          idx <= idx + IDX_W'(1);
          if (last_chal) begin
            o_resp_valid <= 1'b1;
            state        <= S_RESP;
          end else begin
            o_sft_rst <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_RESP: begin
          if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
            idx          <= '0;
            resp         <= '0;
            state        <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_resp_sched.sv
// Directed self-checking bench for puf_resp_sched with a hand-driven datapath;
// the timeout scenario runs only when PUF_RESP_SCHED_WDOG_EN is defined.
module tb_puf_resp_sched;

  localparam int MUX_LENGTH   = 16;
  localparam int NUM_CHAL     = 8;
  localparam int CNT_BIT_SIZE = 32;
  localparam int WDOG_LIMIT   = 16;
  localparam int SEL_W        = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    i_chal_valid = 1'b0;
  logic                    o_chal_ready;
  logic [2*SEL_W-1:0]      i_chal_data = '0;
  logic                    i_start = 1'b0;
  logic [CNT_BIT_SIZE-1:0] i_max_count = '0;
  logic [SEL_W-1:0]        o_sel_mux_0;
  logic [SEL_W-1:0]        o_sel_mux_1;
  logic [CNT_BIT_SIZE-1:0] o_max_count;
  logic                    o_sft_rst;
  logic                    o_exec_enable;
  logic                    i_exec_done = 1'b0;
  logic                    i_winner = 1'b0;
  logic                    o_resp_valid;
  logic                    i_resp_ready = 1'b0;
  logic [NUM_CHAL-1:0]     o_resp_data;
  logic                    o_busy;
  logic                    o_err;
  logic                    o_timeout;

  int   checks = 0;
  int   errors = 0;
  int   sft_total = 0;
  int   exec_rise = 0;
  logic exec_prev = 1'b0;

  puf_resp_sched #(
    .MUX_LENGTH   (MUX_LENGTH),
    .NUM_CHAL     (NUM_CHAL),
    .CNT_BIT_SIZE (CNT_BIT_SIZE),
    .WDOG_LIMIT   (WDOG_LIMIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_chal_valid  (i_chal_valid),
    .o_chal_ready  (o_chal_ready),
    .i_chal_data   (i_chal_data),
    .i_start       (i_start),
    .i_max_count   (i_max_count),
    .o_sel_mux_0   (o_sel_mux_0),
    .o_sel_mux_1   (o_sel_mux_1),
    .o_max_count   (o_max_count),
    .o_sft_rst     (o_sft_rst),
    .o_exec_enable (o_exec_enable),
    .i_exec_done   (i_exec_done),
    .i_winner      (i_winner),
    .o_resp_valid  (o_resp_valid),
    .i_resp_ready  (i_resp_ready),
    .o_resp_data   (o_resp_data),
    .o_busy        (o_busy),
    .o_err         (o_err),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  // Pulse and edge counters for soft-reset and exec-enable activity.
  always @(negedge clk) begin
    if (o_sft_rst) sft_total++;
    if (o_exec_enable && !exec_prev) exec_rise++;
    exec_prev = o_exec_enable;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: observed running, expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2*SEL_W-1:0] word);
    @(negedge clk);
    i_chal_valid = 1'b1;
    i_chal_data  = word;
    @(negedge clk);
    i_chal_valid = 1'b0;
    i_chal_data  = '0;
  endtask

  task automatic startBatch(input logic [CNT_BIT_SIZE-1:0] mc);
    @(negedge clk);
    i_start     = 1'b1;
    i_max_count = mc;
    @(negedge clk);
    i_start     = 1'b0;
    i_max_count = '0;
  endtask

  task automatic waitExec(input string tag);
    int n = 0;
    while (!o_exec_enable && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(o_exec_enable), 32'd1);
  endtask

  task automatic doExec(input logic winner, input int delay,
                        input logic [SEL_W-1:0] s0, input logic [SEL_W-1:0] s1);
    waitExec("exec_wait");
    checkOutput("sel0", 32'(o_sel_mux_0), 32'(s0));
    checkOutput("sel1", 32'(o_sel_mux_1), 32'(s1));
    repeat (delay) @(negedge clk);
    checkOutput("exec_held", 32'(o_exec_enable), 32'd1);
    i_exec_done = 1'b1;
    i_winner    = winner;
    @(negedge clk);
    i_exec_done = 1'b0;
    i_winner    = 1'b0;
    checkOutput("exec_drop", 32'(o_exec_enable), 32'd0);
  endtask

  task automatic finishResp(input logic [NUM_CHAL-1:0] expected);
    int n = 0;
    while (!o_resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resp_valid", 32'(o_resp_valid), 32'd1);
    checkOutput("resp_data", 32'(o_resp_data), 32'(expected));
    @(negedge clk);
    checkOutput("resp_hold", 32'(o_resp_data), 32'(expected));
    i_resp_ready = 1'b1;
    @(negedge clk);
    i_resp_ready = 1'b0;
    checkOutput("resp_done_valid", 32'(o_resp_valid), 32'd0);
    checkOutput("resp_done_busy", 32'(o_busy), 32'd0);
    checkOutput("resp_done_data", 32'(o_resp_data), 32'd0);
    checkOutput("resp_done_ready", 32'(o_chal_ready), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_exec"}, 32'(o_exec_enable), 32'd0);
    checkOutput({tag, "_sft"}, 32'(o_sft_rst), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(o_resp_valid), 32'd0);
    checkOutput({tag, "_rdata"}, 32'(o_resp_data), 32'd0);
    checkOutput({tag, "_err"}, 32'(o_err), 32'd0);
    checkOutput({tag, "_tmo"}, 32'(o_timeout), 32'd0);
    checkOutput({tag, "_maxc"}, o_max_count, 32'd0);
    checkOutput({tag, "_sel0"}, 32'(o_sel_mux_0), 32'd0);
    checkOutput({tag, "_sel1"}, 32'(o_sel_mux_1), 32'd0);
    checkOutput({tag, "_ready"}, 32'(o_chal_ready), 32'd0);
  endtask

  initial begin
    int sft_base;
    int exec_base;
    int acc;
    int n;
    logic [3:0] lo;
    logic [3:0] hi;

    // Reset state, then ready rises once reset is released.
    repeat (3) @(negedge clk);
    checkAllZero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(o_chal_ready), 32'd1);

    // Start with an empty buffer is ignored.
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checkOutput("empty_start_busy", 32'(o_busy), 32'd0);
    checkOutput("empty_start_sft", 32'(o_sft_rst), 32'd0);
    @(negedge clk);
    checkOutput("empty_start_busy2", 32'(o_busy), 32'd0);

    // Three challenges, winners 1,0,1, with start-to-exec latency.
    applyStimulus(8'h21);
    applyStimulus(8'h43);
    applyStimulus(8'h65);
    sft_base  = sft_total;
    exec_base = exec_rise;
    @(negedge clk);
    i_start     = 1'b1;
    i_max_count = 32'h1234;
    @(negedge clk);
    i_start     = 1'b0;
    i_max_count = '0;
    checkOutput("lat_sft", 32'(o_sft_rst), 32'd1);
    checkOutput("lat_busy", 32'(o_busy), 32'd1);
    checkOutput("lat_ready_busy", 32'(o_chal_ready), 32'd0);
    @(negedge clk);
    checkOutput("lat_sft_once", 32'(o_sft_rst), 32'd0);
    checkOutput("lat_exec_early", 32'(o_exec_enable), 32'd0);
    @(negedge clk);
    checkOutput("lat_exec_3cyc", 32'(o_exec_enable), 32'd1);
    checkOutput("max_count", o_max_count, 32'h1234);
    doExec(1'b1, 2, 4'd1, 4'd2);
    doExec(1'b0, 0, 4'd3, 4'd4);
    doExec(1'b1, 5, 4'd5, 4'd6);
    finishResp(8'b0000_0101);
    checkOutput("b1_sft_pulses", 32'(sft_total - sft_base), 32'd3);
    checkOutput("b1_exec_count", 32'(exec_rise - exec_base), 32'd3);
    checkOutput("b1_err", 32'(o_err), 32'd0);

    // Equal selects skip the race and raise a sticky error.
    applyStimulus(8'h77);
    applyStimulus(8'h90);
    exec_base = exec_rise;
    startBatch(32'd9);
    doExec(1'b1, 1, 4'd0, 4'd9);
    finishResp(8'b0000_0010);
    checkOutput("b2_exec_count", 32'(exec_rise - exec_base), 32'd1);
    checkOutput("b2_err", 32'(o_err), 32'd1);

    // Start together with a challenge handshake includes that word.
    applyStimulus(8'h21);
    @(negedge clk);
    i_chal_valid = 1'b1;
    i_chal_data  = 8'h43;
    i_start      = 1'b1;
    i_max_count  = 32'd5;
    @(negedge clk);
    i_chal_valid = 1'b0;
    i_start      = 1'b0;
    checkOutput("combo_busy", 32'(o_busy), 32'd1);
    checkOutput("combo_err_clr", 32'(o_err), 32'd0);
    doExec(1'b0, 1, 4'd1, 4'd2);
    doExec(1'b1, 1, 4'd3, 4'd4);
    finishResp(8'b0000_0010);

    // Ten held words: only eight fit.
    acc = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      lo = 4'(i);
      hi = 4'(15 - i);
      i_chal_valid = 1'b1;
      i_chal_data  = {hi, lo};
      if (o_chal_ready) acc++;
      @(negedge clk);
    end
    i_chal_valid = 1'b0;
    checkOutput("full_accepted", 32'(acc), 32'd8);
    checkOutput("full_ready", 32'(o_chal_ready), 32'd0);
    startBatch(32'd100);
    for (int k = 0; k < 8; k++) begin
      doExec((k % 3) == 0, 1, 4'(k), 4'(15 - k));
    end
    finishResp(8'h49);

`ifdef PUF_RESP_SCHED_WDOG_EN
    // Datapath never finishes: watchdog zeros the bit and flags timeout.
    applyStimulus(8'h21);
    startBatch(32'd7);
    waitExec("wdog_exec_wait");
    n = 0;
    while (o_exec_enable && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("wdog_cycles", 32'(n), 32'd16);
    finishResp(8'h00);
    checkOutput("wdog_timeout", 32'(o_timeout), 32'd1);
    applyStimulus(8'h21);
    startBatch(32'd7);
    checkOutput("wdog_timeout_clr", 32'(o_timeout), 32'd0);
    doExec(1'b1, 0, 4'd1, 4'd2);
    finishResp(8'h01);
`else
    n = 0;
    checkOutput("no_wdog_timeout", 32'(o_timeout), 32'(n));
`endif

    // Reset during the second race discards the batch.
    applyStimulus(8'h21);
    applyStimulus(8'h43);
    applyStimulus(8'h65);
    startBatch(32'd3);
    doExec(1'b1, 0, 4'd1, 4'd2);
    waitExec("mid_exec_wait");
    rst_n = 1'b0;
    @(negedge clk);
    checkAllZero("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready", 32'(o_chal_ready), 32'd1);
    applyStimulus(8'hA5);
    startBatch(32'd11);
    checkOutput("midrst_maxc", o_max_count, 32'd11);
    doExec(1'b1, 3, 4'd5, 4'd10);
    finishResp(8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
